// File: rtl/aes_sbox_arbiter.sv
// rtl/aes_sbox_arbiter.sv - round-robin owner arbiter sharing one 32-bit AES S-box
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   req, lock     per-requester word-valid and hold-ownership hint
//   req_word      requester i word at [32*i+31:32*i]
//   gnt           registered one-hot ownership
//   rsp_valid     one-hot pulse tagging each returned word to its issuer
//   rsp_word      substituted word, held between pulses
//   sboxw         word driven to the S-box (zero when no owner)
//   new_sboxw     S-box result, SBOX_LAT cycles behind sboxw
//   busy          ownership held or responses still in flight
module aes_sbox_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int SBOX_LAT  = 0,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     lock,
    input  logic [32*NUM_REQ-1:0]  req_word,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_word,
    output logic [31:0]            sboxw,
    input  logic [31:0]            new_sboxw,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   burst_cnt;

    logic               owner_valid;
    logic               accept;
    logic               last_beat;
    logic               release_now;
    logic [IDX_W-1:0]   pick;
    logic               tail_valid;
    logic [IDX_W-1:0]   tail_idx;
    logic               pipe_any;

    // Rotate the request vector so rr_ptr sits at bit 0, take the first set
    // bit as an offset, then map the offset back to an absolute index.
    logic [2*NUM_REQ-1:0] req_rot;
    logic [IDX_W-1:0]     pick_off;
    logic [IDX_W:0]       pick_sum;

    always_comb begin
        req_rot  = {req, req} >> rr_ptr;
        pick_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = IDX_W'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W+1)'(NUM_REQ)) begin
            pick_sum = pick_sum - (IDX_W+1)'(NUM_REQ);
        end
        pick = pick_sum[IDX_W-1:0];
    end

    assign owner_valid = (state == OWN);
    assign accept      = owner_valid & req[owner];
    assign last_beat   = (burst_cnt == CNT_W'(MAX_BURST - 1));
    // Forced release on the last allowed beat overrides the lock hint.
    assign release_now = owner_valid &
                         ((accept & (~lock[owner] | last_beat)) |
                          (~req[owner] & ~lock[owner]));

    assign sboxw = owner_valid ? req_word[32*owner +: 32] : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= pick;
                        gnt   <= NUM_REQ'(1) << pick;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline tracks the S-box latency so each result meets its issuer.
    generate
        if (SBOX_LAT == 0) begin : g_nolat
            assign tail_valid = accept;
            assign tail_idx   = owner;
            assign pipe_any   = 1'b0;
        end else begin : g_lat
            logic [SBOX_LAT-1:0] pipe_valid;
            logic [IDX_W-1:0]    pipe_idx [SBOX_LAT];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_valid <= '0;
                    for (int k = 0; k < SBOX_LAT; k++) begin
                        pipe_idx[k] <= '0;
                    end
                end else begin
                    pipe_valid[0] <= accept;
                    pipe_idx[0]   <= owner;
                    for (int k = 1; k < SBOX_LAT; k++) begin
                        pipe_valid[k] <= pipe_valid[k-1];
                        pipe_idx[k]   <= pipe_idx[k-1];
                    end
                end
            end

            assign tail_valid = pipe_valid[SBOX_LAT-1];
            assign tail_idx   = pipe_idx[SBOX_LAT-1];
            assign pipe_any   = |pipe_valid;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_word  <= 32'h0;
        end else begin
            rsp_valid <= tail_valid ? (NUM_REQ'(1) << tail_idx) : '0;
            if (tail_valid) begin
                rsp_word <= new_sboxw;
            end
        end
    end

    assign busy = owner_valid | pipe_any | (|rsp_valid);

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// tb/tb_aes_sbox_arbiter.sv - scoreboard bench for aes_sbox_arbiter (latency 0 and 2 instances)
module tb_aes_sbox_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [1:0]  req0 = '0, lock0 = '0, gnt0, rspv0;
    logic [63:0] word0 = '0;
    logic [31:0] rspw0, sboxw0, new0;
    logic        busy0;

    logic [1:0]  req2 = '0, lock2 = '0, gnt2, rspv2;
    logic [63:0] word2 = '0;
    logic [31:0] rspw2, sboxw2, new2, s1, s2;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q2 [$];

    always #5 clk = ~clk;

    aes_sbox_arbiter #(.NUM_REQ(2), .SBOX_LAT(0), .MAX_BURST(4)) u0 (
        .clk(clk), .reset_n(reset_n), .req(req0), .lock(lock0), .req_word(word0),
        .gnt(gnt0), .rsp_valid(rspv0), .rsp_word(rspw0), .sboxw(sboxw0),
        .new_sboxw(new0), .busy(busy0));

    aes_sbox_arbiter #(.NUM_REQ(2), .SBOX_LAT(2), .MAX_BURST(4)) u2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .lock(lock2), .req_word(word2),
        .gnt(gnt2), .rsp_valid(rspv2), .rsp_word(rspw2), .sboxw(sboxw2),
        .new_sboxw(new2), .busy(busy2));

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h0;
        if (x != 8'h0) begin
            for (int i = 1; i < 256; i++) begin
                if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [63:0] exp_ent(input logic [1:0] oh, input logic [31:0] w);
        return {30'h0, oh, sub_word(w)};
    endfunction

    // S-box models: combinational for u0, two register stages for u2.
    always_comb new0 = sub_word(sboxw0);
    always @(posedge clk) begin
        s1 <= sub_word(sboxw2);
        s2 <= s1;
    end
    assign new2 = s2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rspv0 != 2'b00) begin
            if (exp_q0.size() == 0) check_eq("u0_rsp_unexpected", {30'h0, rspv0, rspw0}, 64'h0);
            else check_eq("u0_rsp", {30'h0, rspv0, rspw0}, exp_q0.pop_front());
        end
        if (rspv2 != 2'b00) begin
            if (exp_q2.size() == 0) check_eq("u2_rsp_unexpected", {30'h0, rspv2, rspw2}, 64'h0);
            else check_eq("u2_rsp", {30'h0, rspv2, rspw2}, exp_q2.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = '0; lock0 = '0; req2 = '0; lock2 = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    logic [1:0] exp_g [5];

    initial begin
        #2;
        check_eq("rst_gnt", 64'(gnt0), 64'h0);
        check_eq("rst_rspv", 64'(rspv0), 64'h0);
        check_eq("rst_rspw", 64'(rspw0), 64'h0);
        check_eq("rst_busy", 64'(busy0), 64'h0);
        check_eq("rst_sboxw", 64'(sboxw0), 64'h0);
        do_reset();

        // Single request, zero latency.
        req0 = 2'b01; lock0 = 2'b00; word0 = {32'h0, 32'h00010203};
        exp_q0.push_back(exp_ent(2'b01, 32'h00010203));
        step();
        check_eq("single_gnt", 64'(gnt0), 64'h1);
        check_eq("single_sboxw", 64'(sboxw0), 64'h00010203);
        step();
        req0 = 2'b00;
        check_eq("single_rspv", 64'(rspv0), 64'h1);
        check_eq("single_rspw", 64'(rspw0), 64'h637c777b);
        check_eq("single_gnt_rel", 64'(gnt0), 64'h0);
        step();
        check_eq("single_idle_busy", 64'(busy0), 64'h0);
        check_eq("single_hold_rspw", 64'(rspw0), 64'h637c777b);

        // Contention with rr_ptr at 0.
        do_reset();
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        req0 = 2'b11; word0 = {32'hb1b2b3b4, 32'ha0a1a2a3};
        exp_q0.push_back(exp_ent(2'b01, 32'ha0a1a2a3));
        exp_q0.push_back(exp_ent(2'b10, 32'hb1b2b3b4));
        exp_q0.push_back(exp_ent(2'b01, 32'ha0a1a2a3));
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq($sformatf("cont_gnt_%0d", c), 64'(gnt0), 64'(exp_g[c]));
            if (c == 2) check_eq("cont_sboxw_r1", 64'(sboxw0), 64'hb1b2b3b4);
        end
        step();
        req0 = 2'b00;
        repeat (3) step();

        // Requester 1 alone after reset.
        do_reset();
        req0 = 2'b10; word0 = {32'h11223344, 32'h0};
        exp_q0.push_back(exp_ent(2'b10, 32'h11223344));
        step();
        check_eq("r1_first_gnt", 64'(gnt0), 64'h2);
        step();
        req0 = 2'b00;
        repeat (2) step();

        // Locked burst with forced release while requester 1 waits.
        do_reset();
        req0 = 2'b11; lock0 = 2'b01; word0 = {32'h0f0e0d0c, 32'h53535353};
        repeat (4) exp_q0.push_back(exp_ent(2'b01, 32'h53535353));
        exp_q0.push_back(exp_ent(2'b10, 32'h0f0e0d0c));
        for (int c = 1; c <= 4; c++) begin
            step();
            check_eq($sformatf("burst_gnt_%0d", c), 64'(gnt0), 64'h1);
            if (c >= 2) check_eq($sformatf("burst_rspw_%0d", c), 64'(rspw0), 64'hedededed);
        end
        step();
        check_eq("burst_forced_rel", 64'(gnt0), 64'h0);
        check_eq("burst_rspw_4", 64'(rspw0), 64'hedededed);
        step();
        check_eq("burst_next_owner", 64'(gnt0), 64'h2);
        step();
        req0 = 2'b00; lock0 = 2'b00;
        repeat (2) step();

        // Lock stall: owner withholds words but keeps ownership.
        do_reset();
        req0 = 2'b01; lock0 = 2'b01; word0 = {32'h0, 32'h12345678};
        step();
        check_eq("stall_gnt_1", 64'(gnt0), 64'h1);
        req0 = 2'b00;
        for (int c = 2; c <= 3; c++) begin
            step();
            check_eq($sformatf("stall_gnt_%0d", c), 64'(gnt0), 64'h1);
            check_eq($sformatf("stall_busy_%0d", c), 64'(busy0), 64'h1);
            check_eq($sformatf("stall_sboxw_%0d", c), 64'(sboxw0), 64'h12345678);
        end
        step();
        req0 = 2'b01; lock0 = 2'b00; word0 = {32'h0, 32'h9abcdef0};
        exp_q0.push_back(exp_ent(2'b01, 32'h9abcdef0));
        #1;
        check_eq("stall_gnt_4", 64'(gnt0), 64'h1);
        step();
        req0 = 2'b00;
        check_eq("stall_rspv", 64'(rspv0), 64'h1);
        check_eq("stall_release", 64'(gnt0), 64'h0);
        repeat (2) step();

        // Latency 2: back-to-back accepts.
        do_reset();
        req2 = 2'b01; lock2 = 2'b01; word2 = {32'h0, 32'h00000000};
        exp_q2.push_back(exp_ent(2'b01, 32'h00000000));
        exp_q2.push_back(exp_ent(2'b01, 32'h01010101));
        step();
        check_eq("lat_gnt", 64'(gnt2), 64'h1);
        step();
        lock2 = 2'b00; word2 = {32'h0, 32'h01010101};
        step();
        req2 = 2'b00;
        check_eq("lat_no_early", 64'(rspv2), 64'h0);
        check_eq("lat_busy", 64'(busy2), 64'h1);
        step();
        check_eq("lat_rsp1_v", 64'(rspv2), 64'h1);
        check_eq("lat_rsp1_w", 64'(rspw2), 64'h63636363);
        step();
        check_eq("lat_rsp2_v", 64'(rspv2), 64'h1);
        check_eq("lat_rsp2_w", 64'(rspw2), 64'h7c7c7c7c);
        step();
        check_eq("lat_drained", 64'(busy2), 64'h0);

        // Reset one cycle after an accept with responses in flight.
        do_reset();
        req2 = 2'b01; lock2 = 2'b00; word2 = {32'h0, 32'hdeadbeef};
        step();
        check_eq("mrst_gnt_pre", 64'(gnt2), 64'h1);
        step();
        reset_n = 1'b0;
        req2 = 2'b00;
        #1;
        check_eq("mrst_gnt", 64'(gnt2), 64'h0);
        check_eq("mrst_rspv", 64'(rspv2), 64'h0);
        check_eq("mrst_busy", 64'(busy2), 64'h0);
        check_eq("mrst_sboxw", 64'(sboxw2), 64'h0);
        step();
        reset_n = 1'b1;
        repeat (5) step();
        check_eq("mrst_busy_after", 64'(busy2), 64'h0);

        check_eq("u0_queue_empty", 64'(exp_q0.size()), 64'h0);
        check_eq("u2_queue_empty", 64'(exp_q2.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
